// File: rtl/fir_pkg.sv
// Shared constants and helpers for the FIR output stage.
// Widths, saturation limits and the decimation select encoding.
package fir_pkg;

    localparam int FIR_IN_W  = 16;
    localparam int FIR_OUT_W = 8;
    localparam int SAT_MAX   = 127;
    localparam int SAT_MIN   = -128;

    typedef enum logic [1:0] {
        DECIM_1 = 2'd0,
        DECIM_2 = 2'd1,
        DECIM_4 = 2'd2,
        DECIM_8 = 2'd3
    } decim_e;

    // Counter value at which the next sample is pushed (N-1).
    function automatic logic [3:0] decim_last(input logic [1:0] decim);
        return (4'd1 << decim) - 4'd1;
    endfunction

endpackage

// File: rtl/fir_output_stage_if.sv
// Sample stream in from the FIR core and drained result stream out.
// The output stage is the slave; the FIR core plus host act as master.
interface fir_output_stage_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 8,
    parameter int DEPTH = 4
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic signed [IN_W-1:0] y_in;
    logic                   y_valid;
    logic                   rd_en;
    logic [OUT_W-1:0]       dout;
    logic                   dout_valid;
    logic [LW-1:0]          level;

    modport master (
        output y_in, y_valid, rd_en,
        input  dout, dout_valid, level
    );

    modport slave (
        input  y_in, y_valid, rd_en,
        output dout, dout_valid, level
    );

endinterface

// File: rtl/fir_out_fifo.sv
// Show-ahead FIFO: head shows the oldest entry, zero when empty.
// A push while full is accepted only if a pop frees the slot that cycle.
module fir_out_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8,
    parameter int LW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             valid,
    output logic [LW-1:0]    level,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [LW-1:0]    cnt;
    logic             do_pop;
    logic             do_push;

    assign valid   = (cnt != '0);
    assign full    = (cnt == LW'(DEPTH));
    assign do_pop  = pop && valid;
    assign do_push = push && (!full || do_pop);
    assign level   = cnt;
    assign head    = valid ? mem[rptr] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else if (clr) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            cnt <= cnt + LW'(do_push) - LW'(do_pop);
        end
    end

    // Storage needs no reset: head is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_push && !clr) mem[wptr] <= din;
    end

endmodule

// File: rtl/fir_output_stage.sv
// FIR result post-processing: rounding shift, 8-bit saturation,
// decimation by 1/2/4/8 and a show-ahead output FIFO with sticky flags.
module fir_output_stage
    import fir_pkg::*;
#(
    parameter int IN_W  = FIR_IN_W,
    parameter int OUT_W = FIR_OUT_W,
    parameter int DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    fir_output_stage_if.slave   bus,
    input  logic [3:0]          shift,
    input  logic [1:0]          decim,
    input  logic                clr,
    output logic                sat_flag,
    output logic                ovf_flag
);
    localparam int LW = $clog2(DEPTH) + 1;
    localparam logic signed [IN_W:0] HI = (IN_W+1)'(SAT_MAX);
    localparam logic signed [IN_W:0] LO = (IN_W+1)'(SAT_MIN);

    logic signed [IN_W:0] ext;
    logic signed [IN_W:0] half;
    logic signed [IN_W:0] rnd;
    logic signed [IN_W:0] shr;
    logic [OUT_W-1:0]     sample;
    logic                 sat;

    logic [2:0]           cnt;
    logic                 push;
    logic                 full;
    logic                 pop_ok;
    logic                 accept;
    logic                 drop;

    // One guard bit keeps the rounding add from wrapping.
    always_comb begin
        ext    = {bus.y_in[IN_W-1], bus.y_in};
        half   = '0;
        if (shift != 4'd0) half = (IN_W+1)'(1) << (shift - 4'd1);
        rnd    = ext + half;
        shr    = rnd >>> shift;
        sat    = 1'b0;
        sample = shr[OUT_W-1:0];
        if (shr > HI) begin
            sat    = 1'b1;
            sample = OUT_W'(SAT_MAX);
        end else if (shr < LO) begin
            sat    = 1'b1;
            sample = OUT_W'(SAT_MIN);
        end
    end

    // '>=' lets a shrinking decim flush at the next sample.
    assign push   = bus.y_valid && ({1'b0, cnt} >= decim_last(decim));
    assign pop_ok = bus.rd_en && bus.dout_valid;
    assign accept = push && (!full || pop_ok);
    assign drop   = push && full && !pop_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            sat_flag <= 1'b0;
            ovf_flag <= 1'b0;
        end else if (clr) begin
            cnt      <= '0;
            sat_flag <= 1'b0;
            ovf_flag <= 1'b0;
        end else begin
            if (push)             cnt <= '0;
            else if (bus.y_valid) cnt <= cnt + 3'd1;
            if (accept && sat) sat_flag <= 1'b1;
            if (drop)          ovf_flag <= 1'b1;
        end
    end

    fir_out_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (OUT_W),
        .LW    (LW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (bus.rd_en),
        .clr   (clr),
        .din   (sample),
        .head  (bus.dout),
        .valid (bus.dout_valid),
        .level (bus.level),
        .full  (full)
    );

endmodule
